// File: rtl/mem_bus_pkg.sv
// Shared memory-request bus types: function codes, request record and arbiter states.
package mem_bus_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_STRB_W = MEM_DATA_W / 8;

  localparam logic FUNC_RD = 1'b0;
  localparam logic FUNC_WR = 1'b1;

  typedef struct packed {
    logic                  is_cached;
    logic                  is_aligned;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] data;
    logic                  func;
    logic [MEM_STRB_W-1:0] wstrb;
  } mem_req_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_RESP
  } arb_state_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin select: one-hot grant among two requesters, prio breaks ties.
module rr_pick2 (
  input  logic [1:0] valid,
  input  logic       prio,
  output logic [1:0] grant,
  output logic       any
);

  // prio names the master that wins when both request.
  assign grant[0] = valid[0] & (~valid[1] | ~prio);
  assign grant[1] = valid[1] & (~valid[0] |  prio);
  assign any      = valid[0] | valid[1];

endmodule

// File: rtl/mmio_arbiter_2x1.sv
// Two-master to one-slave memory-request arbiter with round-robin grant, one
// outstanding transaction and a response buffer for the device's one-cycle strobe.
module mmio_arbiter_2x1
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic                clock,
  input  logic                reset,

  output logic                in0_req_ready,
  input  logic                in0_req_valid,
  input  logic                in0_req_bits_is_cached,
  input  logic                in0_req_bits_is_aligned,
  input  logic [ADDR_W-1:0]   in0_req_bits_addr,
  input  logic [DATA_W-1:0]   in0_req_bits_data,
  input  logic                in0_req_bits_func,
  input  logic [DATA_W/8-1:0] in0_req_bits_wstrb,
  input  logic                in0_resp_ready,
  output logic                in0_resp_valid,
  output logic [DATA_W-1:0]   in0_resp_bits_data,

  output logic                in1_req_ready,
  input  logic                in1_req_valid,
  input  logic                in1_req_bits_is_cached,
  input  logic                in1_req_bits_is_aligned,
  input  logic [ADDR_W-1:0]   in1_req_bits_addr,
  input  logic [DATA_W-1:0]   in1_req_bits_data,
  input  logic                in1_req_bits_func,
  input  logic [DATA_W/8-1:0] in1_req_bits_wstrb,
  input  logic                in1_resp_ready,
  output logic                in1_resp_valid,
  output logic [DATA_W-1:0]   in1_resp_bits_data,

  input  logic                out_req_ready,
  output logic                out_req_valid,
  output logic                out_req_bits_is_cached,
  output logic                out_req_bits_is_aligned,
  output logic [ADDR_W-1:0]   out_req_bits_addr,
  output logic [DATA_W-1:0]   out_req_bits_data,
  output logic                out_req_bits_func,
  output logic [DATA_W/8-1:0] out_req_bits_wstrb,
  output logic                out_resp_ready,
  input  logic                out_resp_valid,
  input  logic [DATA_W-1:0]   out_resp_bits_data
);

  arb_state_e        state_q, state_d;
  logic              prio_q, prio_d;
  logic              gnt_q, gnt_d;
  mem_req_t          req_q, req_d;
  mem_req_t          in0_req, in1_req;
  logic [DATA_W-1:0] resp_q, resp_d;
  logic [1:0]        pick;
  logic              pick_any;

  assign in0_req = '{is_cached:  in0_req_bits_is_cached,
                     is_aligned: in0_req_bits_is_aligned,
                     addr:       in0_req_bits_addr,
                     data:       in0_req_bits_data,
                     func:       in0_req_bits_func,
                     wstrb:      in0_req_bits_wstrb};

  assign in1_req = '{is_cached:  in1_req_bits_is_cached,
                     is_aligned: in1_req_bits_is_aligned,
                     addr:       in1_req_bits_addr,
                     data:       in1_req_bits_data,
                     func:       in1_req_bits_func,
                     wstrb:      in1_req_bits_wstrb};

  rr_pick2 u_pick (
    .valid ({in1_req_valid, in0_req_valid}),
    .prio  (prio_q),
    .grant (pick),
    .any   (pick_any)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      prio_q  <= 1'b0;
      gnt_q   <= 1'b0;
      req_q   <= '{func: FUNC_RD, default: '0};
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      gnt_q   <= gnt_d;
      req_q   <= req_d;
      resp_q  <= resp_d;
    end
  end

  // Grant readiness is gated by reset so a master never sees a handshake that is then discarded.
  always_comb begin
    state_d       = state_q;
    prio_d        = prio_q;
    gnt_d         = gnt_q;
    req_d         = req_q;
    resp_d        = resp_q;
    in0_req_ready = 1'b0;
    in1_req_ready = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any && !reset) begin
          in0_req_ready = pick[0];
          in1_req_ready = pick[1];
          gnt_d         = pick[1];
          prio_d        = pick[0];
          req_d         = pick[1] ? in1_req : in0_req;
          state_d       = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        if (out_req_ready) state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (out_resp_valid) begin
          resp_d  = out_resp_bits_data;
          state_d = ARB_RESP;
        end
      end
      ARB_RESP: begin
        if (gnt_q ? in1_resp_ready : in0_resp_ready) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign out_req_valid           = (state_q == ARB_ISSUE);
  assign out_req_bits_is_cached  = req_q.is_cached;
  assign out_req_bits_is_aligned = req_q.is_aligned;
  assign out_req_bits_addr       = req_q.addr;
  assign out_req_bits_data       = req_q.data;
  assign out_req_bits_func       = req_q.func;
  assign out_req_bits_wstrb      = req_q.wstrb;
  assign out_resp_ready          = (state_q == ARB_WAIT);

  assign in0_resp_valid     = (state_q == ARB_RESP) && !gnt_q;
  assign in1_resp_valid     = (state_q == ARB_RESP) &&  gnt_q;
  assign in0_resp_bits_data = resp_q;
  assign in1_resp_bits_data = resp_q;

  // The device ignores resp_ready, so a strobe outside WAIT would be silently lost.
  resp_outside_wait_a: assert property (@(posedge clock) disable iff (reset)
    !(out_resp_valid && state_q != ARB_WAIT));

endmodule

// File: tb/tb_mmio_arbiter_2x1.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// transaction-level model of the arbiter.
module tb_mmio_arbiter_2x1;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;

  logic          in0_req_ready, in0_req_valid, in0_req_bits_is_cached, in0_req_bits_is_aligned;
  logic [AW-1:0] in0_req_bits_addr;
  logic [DW-1:0] in0_req_bits_data;
  logic          in0_req_bits_func;
  logic [SW-1:0] in0_req_bits_wstrb;
  logic          in0_resp_ready, in0_resp_valid;
  logic [DW-1:0] in0_resp_bits_data;

  logic          in1_req_ready, in1_req_valid, in1_req_bits_is_cached, in1_req_bits_is_aligned;
  logic [AW-1:0] in1_req_bits_addr;
  logic [DW-1:0] in1_req_bits_data;
  logic          in1_req_bits_func;
  logic [SW-1:0] in1_req_bits_wstrb;
  logic          in1_resp_ready, in1_resp_valid;
  logic [DW-1:0] in1_resp_bits_data;

  logic          out_req_ready, out_req_valid, out_req_bits_is_cached, out_req_bits_is_aligned;
  logic [AW-1:0] out_req_bits_addr;
  logic [DW-1:0] out_req_bits_data;
  logic          out_req_bits_func;
  logic [SW-1:0] out_req_bits_wstrb;
  logic          out_resp_ready, out_resp_valid;
  logic [DW-1:0] out_resp_bits_data;

  mmio_arbiter_2x1 #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock                   (clock),
    .reset                   (reset),
    .in0_req_ready           (in0_req_ready),
    .in0_req_valid           (in0_req_valid),
    .in0_req_bits_is_cached  (in0_req_bits_is_cached),
    .in0_req_bits_is_aligned (in0_req_bits_is_aligned),
    .in0_req_bits_addr       (in0_req_bits_addr),
    .in0_req_bits_data       (in0_req_bits_data),
    .in0_req_bits_func       (in0_req_bits_func),
    .in0_req_bits_wstrb      (in0_req_bits_wstrb),
    .in0_resp_ready          (in0_resp_ready),
    .in0_resp_valid          (in0_resp_valid),
    .in0_resp_bits_data      (in0_resp_bits_data),
    .in1_req_ready           (in1_req_ready),
    .in1_req_valid           (in1_req_valid),
    .in1_req_bits_is_cached  (in1_req_bits_is_cached),
    .in1_req_bits_is_aligned (in1_req_bits_is_aligned),
    .in1_req_bits_addr       (in1_req_bits_addr),
    .in1_req_bits_data       (in1_req_bits_data),
    .in1_req_bits_func       (in1_req_bits_func),
    .in1_req_bits_wstrb      (in1_req_bits_wstrb),
    .in1_resp_ready          (in1_resp_ready),
    .in1_resp_valid          (in1_resp_valid),
    .in1_resp_bits_data      (in1_resp_bits_data),
    .out_req_ready           (out_req_ready),
    .out_req_valid           (out_req_valid),
    .out_req_bits_is_cached  (out_req_bits_is_cached),
    .out_req_bits_is_aligned (out_req_bits_is_aligned),
    .out_req_bits_addr       (out_req_bits_addr),
    .out_req_bits_data       (out_req_bits_data),
    .out_req_bits_func       (out_req_bits_func),
    .out_req_bits_wstrb      (out_req_bits_wstrb),
    .out_resp_ready          (out_resp_ready),
    .out_resp_valid          (out_resp_valid),
    .out_resp_bits_data      (out_resp_bits_data)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  // Device knobs, changed only right after a negedge sample.
  bit          dev_random = 1'b0;
  int          dev_delay = 0;
  int          dev_stall_left = 0;
  logic [31:0] dev_data = '0;

  // Simulated device: accepts when ready, answers with one strobe after the delay, ignores resp_ready.
  initial begin : device
    bit seen_fire, seen_valid, seen_ready, seen_reset, pend;
    int cnt;
    out_req_ready = 1'b0; out_resp_valid = 1'b0; out_resp_bits_data = '0;
    pend = 1'b0; cnt = 0;
    forever begin
      @(negedge clock);
      seen_valid = out_req_valid;
      seen_ready = out_req_ready;
      seen_fire  = out_req_valid && out_req_ready;
      seen_reset = reset;
      @(posedge clock);
      #1;
      out_resp_valid = 1'b0;
      if (seen_reset) begin
        pend = 1'b0;
      end else begin
        if (seen_valid && !seen_ready && dev_stall_left > 0) dev_stall_left--;
        if (seen_fire) begin
          pend = 1'b1;
          cnt  = dev_random ? int'($urandom_range(0, 3)) : dev_delay;
        end else if (pend) begin
          cnt--;
        end
        if (pend && cnt <= 0) begin
          out_resp_valid     = 1'b1;
          out_resp_bits_data = dev_random ? $urandom : dev_data;
          pend               = 1'b0;
        end
      end
      out_req_ready = dev_random ? ($urandom_range(0, 2) != 0) : (dev_stall_left == 0);
    end
  end

  // Transaction-level model: at most one request in flight, tracked by lifecycle flags.
  bit          check_en = 1'b0;
  bit          m_busy = 1'b0, m_issued = 1'b0, m_got = 1'b0, m_owner = 1'b0, m_prio = 1'b0;
  logic [63:0] m_addr_data = '0;
  logic [6:0]  m_misc = '0;
  logic [31:0] m_resp = '0;

  task automatic checkOutput();
    logic e_r0, e_r1;
    e_r0 = 1'b0;
    e_r1 = 1'b0;
    if (!reset && !m_busy) begin
      if (in0_req_valid && in1_req_valid) begin
        e_r0 = !m_prio;
        e_r1 = m_prio;
      end else begin
        e_r0 = in0_req_valid;
        e_r1 = in1_req_valid;
      end
    end
    chk("in0_req_ready", in0_req_ready, e_r0);
    chk("in1_req_ready", in1_req_ready, e_r1);
    chk("out_req_valid", out_req_valid, m_busy && !m_issued);
    if (m_busy && !m_issued) begin
      chk("out_req_addr_data", {out_req_bits_addr, out_req_bits_data}, m_addr_data);
      chk("out_req_misc", {out_req_bits_is_cached, out_req_bits_is_aligned, out_req_bits_func,
                           out_req_bits_wstrb}, m_misc);
    end
    chk("out_resp_ready", out_resp_ready, m_issued && !m_got);
    chk("in0_resp_valid", in0_resp_valid, m_got && !m_owner);
    chk("in1_resp_valid", in1_resp_valid, m_got && m_owner);
    if (m_got) chk("resp_data", m_owner ? in1_resp_bits_data : in0_resp_bits_data, m_resp);

    if (reset) begin
      m_busy = 0; m_issued = 0; m_got = 0; m_prio = 0;
    end else if (!m_busy) begin
      if (e_r0 || e_r1) begin
        m_busy  = 1;
        m_owner = e_r1;
        m_prio  = e_r0;
        if (e_r1) begin
          m_addr_data = {in1_req_bits_addr, in1_req_bits_data};
          m_misc = {in1_req_bits_is_cached, in1_req_bits_is_aligned, in1_req_bits_func, in1_req_bits_wstrb};
        end else begin
          m_addr_data = {in0_req_bits_addr, in0_req_bits_data};
          m_misc = {in0_req_bits_is_cached, in0_req_bits_is_aligned, in0_req_bits_func, in0_req_bits_wstrb};
        end
      end
    end else if (!m_issued) begin
      if (out_req_ready) m_issued = 1;
    end else if (!m_got) begin
      if (out_resp_valid) begin
        m_got  = 1;
        m_resp = out_resp_bits_data;
      end
    end else if (m_owner ? in1_resp_ready : in0_resp_ready) begin
      m_busy = 0; m_issued = 0; m_got = 0;
    end
  endtask

  always @(negedge clock) if (check_en) checkOutput();

  bit fire0 = 1'b0, fire1 = 1'b0;

  task automatic applyStimulus();
    if (in0_req_valid && fire0) in0_req_valid = 1'b0;
    if (!in0_req_valid && $urandom_range(0, 2) == 0) begin
      in0_req_valid = 1'b1;
      in0_req_bits_addr = $urandom; in0_req_bits_data = $urandom;
      in0_req_bits_func = 1'($urandom_range(0, 1)); in0_req_bits_wstrb = 4'($urandom_range(0, 15));
      in0_req_bits_is_cached = 1'($urandom_range(0, 1)); in0_req_bits_is_aligned = 1'($urandom_range(0, 1));
    end
    if (in1_req_valid && fire1) in1_req_valid = 1'b0;
    if (!in1_req_valid && $urandom_range(0, 2) == 0) begin
      in1_req_valid = 1'b1;
      in1_req_bits_addr = $urandom; in1_req_bits_data = $urandom;
      in1_req_bits_func = 1'($urandom_range(0, 1)); in1_req_bits_wstrb = 4'($urandom_range(0, 15));
      in1_req_bits_is_cached = 1'($urandom_range(0, 1)); in1_req_bits_is_aligned = 1'($urandom_range(0, 1));
    end
    in0_resp_ready = ($urandom_range(0, 3) != 0);
    in1_resp_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic reset_dut();
    cycle();
    reset = 1'b1; in0_req_valid = 1'b0; in1_req_valid = 1'b0;
    sample();
    cycle();
    sample();
    check_en = 1'b1;
    cycle();
    reset = 1'b0;
    sample();
  endtask

  initial begin
    int n;
    in0_req_valid = 0; in0_req_bits_is_cached = 0; in0_req_bits_is_aligned = 0; in0_req_bits_addr = '0;
    in0_req_bits_data = '0; in0_req_bits_func = 0; in0_req_bits_wstrb = '0; in0_resp_ready = 1;
    in1_req_valid = 0; in1_req_bits_is_cached = 0; in1_req_bits_is_aligned = 0; in1_req_bits_addr = '0;
    in1_req_bits_data = '0; in1_req_bits_func = 0; in1_req_bits_wstrb = '0; in1_resp_ready = 1;

    // Reset values
    reset_dut();
    chk("rst_in0_req_ready", in0_req_ready, 0);
    chk("rst_in1_req_ready", in1_req_ready, 0);
    chk("rst_out_req_valid", out_req_valid, 0);
    chk("rst_out_resp_ready", out_resp_ready, 0);
    chk("rst_resp_valids", {in0_resp_valid, in1_resp_valid}, 0);
    chk("rst_out_req_bits", {out_req_bits_addr, out_req_bits_data}, 0);
    chk("rst_out_req_misc", {out_req_bits_func, out_req_bits_wstrb, out_req_bits_is_cached}, 0);
    chk("rst_resp_data", in0_resp_bits_data, 0);

    // Single read from master 0
    dev_data = 32'hDEADBEEF;
    reset_dut();
    cycle(); in0_req_valid = 1; in0_req_bits_addr = 32'h1000; in0_req_bits_func = 0; sample();
    chk("rd_gnt0", in0_req_ready, 1);
    chk("rd_gnt1", in1_req_ready, 0);
    cycle(); in0_req_valid = 0; sample();
    chk("rd_issue", out_req_valid, 1);
    chk("rd_addr", out_req_bits_addr, 32'h1000);
    chk("rd_func", out_req_bits_func, 0);
    cycle(); sample();
    chk("rd_wait", out_resp_ready, 1);
    cycle(); sample();
    chk("rd_resp_v0", in0_resp_valid, 1);
    chk("rd_resp_d", in0_resp_bits_data, 32'hDEADBEEF);
    chk("rd_resp_v1", in1_resp_valid, 0);
    cycle(); sample();
    chk("rd_done", in0_resp_valid, 0);

    // Tie-break after reset
    reset_dut();
    cycle();
    in0_req_valid = 1; in0_req_bits_addr = 32'h100;
    in1_req_valid = 1; in1_req_bits_addr = 32'h200;
    sample();
    chk("tie_first_0", in0_req_ready, 1);
    chk("tie_first_1", in1_req_ready, 0);
    n = 1;
    cycle(); in0_req_valid = 0; sample();
    while (!in1_req_ready && n < 12) begin cycle(); sample(); n++; end
    chk("tie_second", in1_req_ready, 1);
    chk("tie_interval", n, 4);
    cycle(); in1_req_valid = 0; sample();
    n = 0;
    while (!in1_resp_valid && n < 12) begin cycle(); sample(); n++; end
    chk("tie_resp1", in1_resp_valid, 1);
    cycle(); in0_req_valid = 1; in1_req_valid = 1; sample();
    chk("tie_third_0", in0_req_ready, 1);
    chk("tie_third_1", in1_req_ready, 0);
    cycle(); in0_req_valid = 0; in1_req_valid = 0; sample();

    // Device stall: ready low for five ISSUE cycles
    dev_stall_left = 5;
    reset_dut();
    cycle();
    in0_req_valid = 1; in0_req_bits_addr = 32'h3000; in0_req_bits_data = 32'h11223344;
    in0_req_bits_wstrb = 4'hC; in0_req_bits_func = 1;
    sample();
    cycle(); in0_req_valid = 0; sample();
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin cycle(); sample(); end
      chk("stall_valid", out_req_valid, 1);
      chk("stall_fields", {out_req_bits_addr, out_req_bits_data}, 64'h00003000_11223344);
      chk("stall_strb", out_req_bits_wstrb, 4'hC);
      chk("stall_dev_ready", out_req_ready, (k == 5));
    end
    cycle(); sample();
    chk("stall_fired", out_resp_ready, 1);

    // Response backpressure on master 1
    dev_data = 32'h12345678; in1_resp_ready = 0;
    reset_dut();
    cycle(); in1_req_valid = 1; in1_req_bits_addr = 32'h4000; in1_req_bits_func = 0; sample();
    chk("bp_gnt", in1_req_ready, 1);
    cycle(); in1_req_valid = 0; in0_req_valid = 1; in0_req_bits_addr = 32'h5000; sample();
    n = 0;
    while (!in1_resp_valid && n < 12) begin cycle(); sample(); n++; end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin cycle(); sample(); end
      chk("bp_valid", in1_resp_valid, 1);
      chk("bp_data", in1_resp_bits_data, 32'h12345678);
      chk("bp_no_gnt", in0_req_ready, 0);
    end
    cycle(); in1_resp_ready = 1; sample();
    chk("bp_hs_valid", in1_resp_valid, 1);
    chk("bp_hs_no_gnt", in0_req_ready, 0);
    cycle(); sample();
    chk("bp_next_gnt", in0_req_ready, 1);
    chk("bp_idle", in1_resp_valid, 0);
    cycle(); in0_req_valid = 0; sample();

    // Write pass-through from master 1
    reset_dut();
    cycle();
    in1_req_valid = 1; in1_req_bits_addr = 32'h2004; in1_req_bits_data = 32'hA5A5A5A5;
    in1_req_bits_wstrb = 4'b0101; in1_req_bits_func = 1; in1_req_bits_is_cached = 1; in1_req_bits_is_aligned = 0;
    sample();
    chk("wr_gnt", in1_req_ready, 1);
    cycle(); in1_req_valid = 0; sample();
    chk("wr_fields", {out_req_bits_addr, out_req_bits_data}, 64'h00002004_A5A5A5A5);
    chk("wr_strb", out_req_bits_wstrb, 4'b0101);
    chk("wr_func", out_req_bits_func, 1);
    chk("wr_flags", {out_req_bits_is_cached, out_req_bits_is_aligned}, 2'b10);
    n = 0;
    while (!in1_resp_valid && n < 12) begin cycle(); sample(); n++; end
    chk("wr_resp", in1_resp_valid, 1);

    // Reset while waiting for the device
    dev_delay = 10;
    reset_dut();
    cycle(); in0_req_valid = 1; in0_req_bits_addr = 32'h6000; sample();
    cycle(); in0_req_valid = 0; sample();
    cycle(); sample();
    chk("rw_in_wait", out_resp_ready, 1);
    cycle(); reset = 1; sample();
    cycle(); reset = 0; sample();
    chk("rw_readys", {in0_req_ready, in1_req_ready, out_resp_ready}, 0);
    chk("rw_valids", {out_req_valid, in0_resp_valid, in1_resp_valid}, 0);
    for (int k = 0; k < 12; k++) begin
      cycle(); sample();
      chk("rw_no_stale", {in0_resp_valid, in1_resp_valid}, 0);
    end
    dev_delay = 0;
    cycle(); in0_req_valid = 1; in1_req_valid = 1; sample();
    chk("rw_prio_0", in0_req_ready, 1);
    chk("rw_prio_1", in1_req_ready, 0);
    cycle(); in0_req_valid = 0; in1_req_valid = 0; sample();

    // Randomized traffic
    reset_dut();
    dev_random = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      cycle();
      applyStimulus();
      sample();
      fire0 = in0_req_valid && in0_req_ready;
      fire1 = in1_req_valid && in1_req_ready;
    end
    cycle(); in0_req_valid = 0; in1_req_valid = 0; in0_resp_ready = 1; in1_resp_ready = 1; sample();
    repeat (10) begin cycle(); sample(); end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/mmio_arbiter_2x1.md
# mmio_arbiter_2x1

Two-master, one-slave arbiter on the memory-request bus, placed directly upstream of the simulated device model. Masters are the instruction-fetch and data-access paths. It grants one master at a time with round-robin priority, registers the winning request, and holds one transaction outstanding. It also buffers the device's single-cycle response pulse and routes it back to the granted master. The buffer is required because the device ignores `resp_ready`.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width. `wstrb` is `DATA_W/8` bits.
- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in0_req_ready`  out  1  master 0 request accepted this cycle.
- `in0_req_valid`  in  1  master 0 request present.
- `in0_req_bits_is_cached`, `in0_req_bits_is_aligned`  in  1 each  passed through unchanged.
- `in0_req_bits_addr`  in  ADDR_W  byte address.
- `in0_req_bits_data`  in  DATA_W  write data.
- `in0_req_bits_func`  in  1  0 = read, 1 = write.
- `in0_req_bits_wstrb`  in  DATA_W/8  byte enables.
- `in0_resp_ready`  in  1  master 0 can take its response.
- `in0_resp_valid`  out  1  response for master 0.
- `in0_resp_bits_data`  out  DATA_W  read data; undefined for writes.
- `in1_*`: identical set of ports for master 1.
- `out_req_*`: same request fields as the `in*_req_*` ports, driven toward the device, with `out_req_ready` as an input.
- `out_resp_ready`  out  1  response handshake toward the device.
- `out_resp_valid`  in  1  device response strobe.
- `out_resp_bits_data`  in  DATA_W  device response data.

## Operation
State machine with four states: IDLE, ISSUE, WAIT, RESP.

- **IDLE**
  - Grant rule: if exactly one `inN_req_valid` is high, grant that master. If both are high, grant the master selected by the priority bit `prio`.
  - On grant: assert only that master's `inN_req_ready`, combinationally in the same cycle. Latch all request fields and the owner id `gnt`. Go to ISSUE.
  - Priority update: `prio` becomes the non-granted master, so a master that was just served loses the next tie.
- **ISSUE**
  - Drive `out_req_valid = 1` with the latched fields.
  - When `out_req_ready` is high, the request fires. Go to WAIT.
  - Fields are held stable until the request fires.
- **WAIT**
  - `out_resp_ready = 1`.
  - On `out_resp_valid`: capture `out_resp_bits_data` into the response buffer. Go to RESP.
- **RESP**
  - Drive `in[gnt]_resp_valid = 1` with the buffered data. The other master's `resp_valid` stays 0.
  - When `in[gnt]_resp_ready` is high: go to IDLE.
  - A new grant happens no earlier than the cycle after that return to IDLE.
- **Rules in every state**
  - `out_resp_ready = 0` outside WAIT. An `out_resp_valid` pulse outside WAIT is a protocol violation: simulation-only assertion fires and the data is dropped.
  - Both `inN_req_ready` are 0 outside IDLE.
  - Requests are never reordered or merged. `is_cached`, `is_aligned` and `wstrb` are passed through without interpretation.

## Timing
- **Reset values:**
  - State returns to IDLE and `prio` resets to master 0.
  - All `*_valid` and `*_ready` outputs reset to 0.
  - `out_req_bits_*` and `inN_resp_bits_data` reset to 0.
- **Minimum latency:** master request fires in cycle t.
  - `out_req_valid` is high in t+1; the device accepts in t+1.
  - Device response arrives in t+2.
  - `inN_resp_valid` is high in t+3.
  - Best-case issue interval is one transaction per 4 cycles.
- **Handshake rules:**
  - Master side: `valid` must not depend on `ready`.
  - The arbiter's `inN_req_ready` may depend on both `in*_req_valid` (combinational grant).
- **Simultaneous events:**
  - Both masters valid in IDLE: only the `prio` master gets `ready`.
  - `out_req_ready` held low: stay in ISSUE indefinitely with fields stable.
  - Master response backpressure: the buffer holds the data. The device is never stalled, since it has already been acknowledged.
- **Reset mid-transaction:** reset wins over every transition. Any latched request or buffered response is discarded with no response to the master. The device side is reset in the same cycle by the shared reset.

## Structure
- **Shared package `mem_bus_pkg`:**
  - `FUNC_RD = 1'b0` and `FUNC_WR = 1'b1`.
  - `mem_req_t` struct holding is_cached, is_aligned, addr, data, func and wstrb.
  - Arbiter state enum `arb_state_e`.
- **Sub-module `rr_pick2`:** combinational two-way round-robin select. Inputs are the two valids and `prio`; outputs are the one-hot grant and `any`. Reused by later N-to-1 fabrics.
- All remaining logic is one always-block FSM plus request and response registers.

## Test plan
- **Single read:** master 0 reads `0x1000`; device returns `0xDEADBEEF` → `in0_resp_valid` at t+3 with `0xDEADBEEF`; `in1_resp_valid` stays 0.
- **Tie-break:** both masters valid in the same IDLE cycle after reset → master 0 is granted first and master 1 next. Then both valid again → master 0 granted.
- **Device stall:** `out_req_ready` held low for 5 cycles → `out_req_valid` stays high and addr/data/wstrb stay constant; request fires on cycle 6.
- **Response backpressure:** `in1_resp_ready` held low for 4 cycles after a read returns `0x12345678` → `in1_resp_valid` is held with constant data; no new grant until the handshake completes.
- **Write pass-through:** master 1 writes `0xA5A5A5A5` with `wstrb = 0b0101` to `0x2004` → the device sees exactly those fields with `func = 1`; master 1 receives a response.
- **Reset in WAIT:** assert reset for one cycle while in WAIT → all valids and readys are 0 the next cycle, state is IDLE, `prio` is 0, and no stale response is delivered.
